reduce_gate_pipe: RTL and testbench
===================================

// Module: reduce_gate_pipe
// PURPOSE
//   Parametrised, pipelined N-input bitwise reduction gate: AND, OR, XOR or NAND of
//   NUM_IN operands, each WIDTH bits, selected per transaction.
//   Generalises the fixed 3-input 1-bit AND cell to any input count and width.
//   One register level per tree level, so wide reductions meet timing.
//   Valid/ready on both sides; sits between CPU datapath producers (condition, flag and
//   mask logic) and their consumers.
// PARAMETERS
//   WIDTH    1  bits per operand and per result
//   NUM_IN   3  operand count, >=1
//   LAT      derived = max(1, $clog2(NUM_IN)); pipeline depth in stages (not overridable)
// PORTS
//   clk        in   1             rising-edge clock
//   rst_n      in   1             async active-low reset
//   in_valid   in   1             operand set valid
//   in_ready   out  1             block can accept this cycle
//   in_mode    in   2             0=AND 1=OR 2=XOR 3=NAND; captured with data
//   in_data    in   NUM_IN*WIDTH  operand k = in_data[k*WIDTH +: WIDTH]
//   out_valid  out  1             result valid
//   out_ready  in   1             consumer accepts result
//   out_data   out  WIDTH         reduction result
//   out_mode   out  2             mode the result was computed with
// BEHAVIOUR
//   Reset (rst_n=0, async):
//   - all stage valid bits, out_valid, out_data and out_mode clear to 0.
//   - in_ready=1 once reset is released.
//   Tree:
//   - stage s combines adjacent pairs of level s-1 using the op for the captured mode.
//   - NAND uses AND in the tree; the final stage inverts.
//   - odd leftover operand at a level is paired with the identity:
//     all-ones for AND/NAND, zero for OR/XOR.
//   - NUM_IN=1: single stage; out = operand (inverted for NAND).
//   Stages:
//   - each stage holds {valid, mode, partials}; mode travels with its data.
//   - no cross-transaction mixing.
//   Flow control (single global enable):
//   - adv = !out_valid || out_ready.
//   - when adv=1, every stage loads from its predecessor.
//   - stage 0 loads {in_valid, in_mode, in_data}.
//   - in_ready = adv (combinational from out_ready and out_valid; no input-to-ready path).
//   - handshake occurs when in_valid && in_ready.
//   - when adv=0, all stages hold; out_data and out_mode stay stable while out_valid=1.
//   - bubbles (invalid stages) propagate as-is and are not collapsed.
//   Latency and throughput:
//   - input accepted at edge E appears with out_valid=1 after edge E+LAT-1
//     (i.e. visible LAT cycles after acceptance), given no stall.
//   - throughput: 1 result per cycle at out_ready=1.
//   - in_valid low while adv=1 inserts a bubble; out_valid drops for that slot.
//   Mode changes:
//   - a mode change between back-to-back inputs is legal.
//   - each result reflects its own mode.
//   Reset mid-operation: all in-flight transactions are discarded; no partial results
//   appear after reset.
//   Width rules:
//   - purely bitwise; bit i of out depends only on bit i of each operand.
//   - no carries, no width growth.
// TESTING
//   1. W=1,N=3, AND, all 8 combos back-to-back, out_ready=1
//      -> out_data 0,0,0,0,0,0,0,1 in order; out_valid first high 2 cycles after
//      first accept; 8 consecutive valid cycles.
//   2. W=8,N=5, OR {01,02,04,08,10} -> 1F; XOR {FF,0F,F0,00,AA} -> AA;
//      NAND {FF,FF,FF,FF,FE} -> 01.
//   3. Mode per beat: AND, OR, XOR, NAND on {1,0,1}
//      -> out 0,1,0,1 with out_mode 0,1,2,3.
//   4. Backpressure: stream of 6 AND beats, out_ready low for 3 cycles mid-stream
//      -> in_ready low exactly those cycles; out_data stable; no loss or duplication;
//      6 results in order.
//   5. rst_n pulsed low asynchronously (not clock-aligned) with 2 beats in flight
//      -> out_valid=0 immediately; no stale result after release; next beat's
//      result correct with LAT latency.
//   6. N=1,W=4, NAND on 4'b1010 -> 4'b0101 after 1 cycle;
//      N=4, in_valid gaps -> out_valid gaps match.

Source files
------------

// File: rtl/reduce_gate_pipe.sv
// reduce_gate_pipe: pipelined N-input bitwise AND/OR/XOR/NAND reduction.
// Each register stage is one level of a pairwise tree, and a single global
// advance enable moves the whole pipe. Mode, valid and partials stay in
// lock-step, so back-to-back beats with different modes never mix.

// One tree level: pairs adjacent partials from the previous level and
// registers the result together with its valid bit and mode.
module reduce_gate_stage #(
    parameter int WIDTH  = 1,
    parameter int NUM_IN = 3,
    parameter int CNT_IN = 3,    // live partials entering this level
    parameter bit LAST   = 1'b0  // final level applies the NAND inversion
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         adv_i,
    input  logic                         vld_i,
    input  logic [1:0]                   mode_i,
    input  logic [NUM_IN-1:0][WIDTH-1:0] data_i,
    output logic                         vld_o,
    output logic [1:0]                   mode_o,
    output logic [NUM_IN-1:0][WIDTH-1:0] data_o
);
    localparam logic [1:0] M_OR   = 2'd1;
    localparam logic [1:0] M_XOR  = 2'd2;
    localparam logic [1:0] M_NAND = 2'd3;

    logic                           vld_q;
    logic [1:0]                     mode_q;
    logic [NUM_IN-1:0][WIDTH-1:0]   data_q;
    logic [NUM_IN-1:0][WIDTH-1:0]   data_d;
    // Zero-extended copy so the odd-pair lookahead never indexes past the end.
    logic [2*NUM_IN-1:0][WIDTH-1:0] ext;
    logic [WIDTH-1:0]               ident;
    logic [WIDTH-1:0]               a;
    logic [WIDTH-1:0]               b;

    // Combine pairs; an odd leftover partial meets the identity of the op,
    // which also makes a single-operand level a plain pass-through.
    always_comb begin
        ext    = {{(NUM_IN*WIDTH){1'b0}}, data_i};
        ident  = (mode_i == M_OR || mode_i == M_XOR) ? '0 : '1;
        data_d = '0;
        a      = '0;
        b      = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (2*i < CNT_IN) begin
                a = ext[2*i];
                b = (2*i + 1 < CNT_IN) ? ext[2*i + 1] : ident;
                case (mode_i)
                    M_OR:    data_d[i] = a | b;
                    M_XOR:   data_d[i] = a ^ b;
                    default: data_d[i] = a & b;  // AND, and NAND before inversion
                endcase
            end
        end
        if (LAST && mode_i == M_NAND) data_d[0] = ~data_d[0];
    end

    // Stage register: loads from the predecessor whenever the pipe advances.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= 1'b0;
            mode_q <= 2'd0;
            data_q <= '0;
        end else if (adv_i) begin
            vld_q  <= vld_i;
            mode_q <= mode_i;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign mode_o = mode_q;
    assign data_o = data_q;
endmodule

module reduce_gate_pipe #(
    parameter int WIDTH  = 1,
    parameter int NUM_IN = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_mode,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [1:0]              out_mode
);
    // Tree depth, at least one register even for a single operand.
    localparam int LAT = (NUM_IN <= 2) ? 1 : $clog2(NUM_IN);

    // Number of live partials entering tree level l.
    function automatic int lvl_cnt(input int l);
        int c;
        c = NUM_IN;
        for (int j = 0; j < l; j++) c = (c + 1) / 2;
        return c;
    endfunction

    // Index 0 is the input port; index s+1 is the output of stage s.
    logic [LAT:0]                         vld_pipe;
    logic [LAT:0][1:0]                    mode_pipe;
    logic [LAT:0][NUM_IN-1:0][WIDTH-1:0]  data_pipe;
    logic                                 adv;
    logic                                 unused_hi;

    assign vld_pipe[0]  = in_valid;
    assign mode_pipe[0] = in_mode;
    assign data_pipe[0] = in_data;

    // One enable for the whole pipe: move unless a result is stuck at the output.
    assign adv      = !vld_pipe[LAT] || out_ready;
    assign in_ready = adv;

    for (genvar s = 0; s < LAT; s++) begin : g_stage
        reduce_gate_stage #(
            .WIDTH  (WIDTH),
            .NUM_IN (NUM_IN),
            .CNT_IN (lvl_cnt(s)),
            .LAST   (s == LAT - 1)
        ) u_stage (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .adv_i  (adv),
            .vld_i  (vld_pipe[s]),
            .mode_i (mode_pipe[s]),
            .data_i (data_pipe[s]),
            .vld_o  (vld_pipe[s+1]),
            .mode_o (mode_pipe[s+1]),
            .data_o (data_pipe[s+1])
        );
    end

    assign out_valid = vld_pipe[LAT];
    assign out_mode  = mode_pipe[LAT];
    assign out_data  = data_pipe[LAT][0];

    // Upper partials of the last level are always zero and go nowhere.
    assign unused_hi = ^data_pipe[LAT];
endmodule

// File: tb/tb_reduce_gate_pipe.sv
// Directed bench for reduce_gate_pipe: four instances cover N=3/W=1,
// N=5/W=8, N=1/W=4 and N=4/W=4. Inputs change at negedge, outputs are
// sampled at negedge (or negedge+1 after a ready change).
module tb_reduce_gate_pipe;
    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    // N=3, W=1 (LAT=2)
    logic       i3_valid, i3_ready, o3_valid, o3_ready;
    logic [1:0] i3_mode, o3_mode;
    logic [2:0] i3_data;
    logic [0:0] o3_data;
    // N=5, W=8 (LAT=3)
    logic        i5_valid, i5_ready, o5_valid, o5_ready;
    logic [1:0]  i5_mode, o5_mode;
    logic [39:0] i5_data;
    logic [7:0]  o5_data;
    // N=1, W=4 (LAT=1)
    logic       i1_valid, i1_ready, o1_valid, o1_ready;
    logic [1:0] i1_mode, o1_mode;
    logic [3:0] i1_data, o1_data;
    // N=4, W=4 (LAT=2)
    logic        i4_valid, i4_ready, o4_valid, o4_ready;
    logic [1:0]  i4_mode, o4_mode;
    logic [15:0] i4_data;
    logic [3:0]  o4_data;

    reduce_gate_pipe #(.WIDTH(1), .NUM_IN(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(i3_valid), .in_ready(i3_ready),
        .in_mode(i3_mode), .in_data(i3_data), .out_valid(o3_valid),
        .out_ready(o3_ready), .out_data(o3_data), .out_mode(o3_mode));
    reduce_gate_pipe #(.WIDTH(8), .NUM_IN(5)) u_d5 (
        .clk(clk), .rst_n(rst_n), .in_valid(i5_valid), .in_ready(i5_ready),
        .in_mode(i5_mode), .in_data(i5_data), .out_valid(o5_valid),
        .out_ready(o5_ready), .out_data(o5_data), .out_mode(o5_mode));
    reduce_gate_pipe #(.WIDTH(4), .NUM_IN(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(i1_valid), .in_ready(i1_ready),
        .in_mode(i1_mode), .in_data(i1_data), .out_valid(o1_valid),
        .out_ready(o1_ready), .out_data(o1_data), .out_mode(o1_mode));
    reduce_gate_pipe #(.WIDTH(4), .NUM_IN(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(i4_valid), .in_ready(i4_ready),
        .in_mode(i4_mode), .in_data(i4_data), .out_valid(o4_valid),
        .out_ready(o4_ready), .out_data(o4_data), .out_mode(o4_mode));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle(input int n);
        i3_valid = 0; i5_valid = 0; i1_valid = 0; i4_valid = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        i3_valid = 0; i3_mode = 0; i3_data = '0; o3_ready = 1;
        i5_valid = 0; i5_mode = 0; i5_data = '0; o5_ready = 1;
        i1_valid = 0; i1_mode = 0; i1_data = '0; o1_ready = 1;
        i4_valid = 0; i4_mode = 0; i4_data = '0; o4_ready = 1;
        #1 rst_n = 1'b0;
        #1;
        tests++; if (o3_valid !== 1'b0) begin fails++; $display("FAIL rst_o3_valid: got %b exp 0", o3_valid); end
        tests++; if (o3_data !== 1'b0) begin fails++; $display("FAIL rst_o3_data: got %b exp 0", o3_data); end
        tests++; if (o3_mode !== 2'd0) begin fails++; $display("FAIL rst_o3_mode: got %0d exp 0", o3_mode); end
        tests++; if (o5_valid !== 1'b0) begin fails++; $display("FAIL rst_o5_valid: got %b exp 0", o5_valid); end
        tests++; if (o5_data !== 8'h00) begin fails++; $display("FAIL rst_o5_data: got %h exp 00", o5_data); end
        tests++; if (o1_data !== 4'h0) begin fails++; $display("FAIL rst_o1_data: got %h exp 0", o1_data); end
        tests++; if (o4_valid !== 1'b0) begin fails++; $display("FAIL rst_o4_valid: got %b exp 0", o4_valid); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++; if (i3_ready !== 1'b1) begin fails++; $display("FAIL rst_i3_ready: got %b exp 1", i3_ready); end
        tests++; if (i5_ready !== 1'b1) begin fails++; $display("FAIL rst_i5_ready: got %b exp 1", i5_ready); end
        tests++; if (i1_ready !== 1'b1) begin fails++; $display("FAIL rst_i1_ready: got %b exp 1", i1_ready); end
        tests++; if (i4_ready !== 1'b1) begin fails++; $display("FAIL rst_i4_ready: got %b exp 1", i4_ready); end
    endtask

    // Eight AND combos back-to-back; only 3'b111 gives 1, first result 2 cycles in.
    task automatic test_and_combos();
        logic ev, ed;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            ev = (k >= 2 && k < 10);
            ed = (k == 9);
            tests++; if (o3_valid !== ev) begin fails++; $display("FAIL and_valid k=%0d: got %b exp %b", k, o3_valid, ev); end
            tests++; if (i3_ready !== 1'b1) begin fails++; $display("FAIL and_ready k=%0d: got %b exp 1", k, i3_ready); end
            if (ev) begin
                tests++; if (o3_data !== ed) begin fails++; $display("FAIL and_data k=%0d: got %b exp %b", k, o3_data, ed); end
            end
            if (k < 8) begin i3_valid = 1; i3_mode = 2'd0; i3_data = 3'(k); end
            else i3_valid = 0;
        end
    endtask

    // W=8, N=5: OR, XOR, NAND beats back-to-back through three stages.
    task automatic test_wide();
        logic [39:0] vec [3];
        logic [7:0]  exp_d [3];
        logic        ev;
        vec[0] = 40'h1008040201; exp_d[0] = 8'h1F;
        vec[1] = 40'hAA00F00FFF; exp_d[1] = 8'hAA;
        vec[2] = 40'hFEFFFFFFFF; exp_d[2] = 8'h01;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            ev = (k >= 3 && k < 6);
            tests++; if (o5_valid !== ev) begin fails++; $display("FAIL wide_valid k=%0d: got %b exp %b", k, o5_valid, ev); end
            if (ev) begin
                tests++; if (o5_data !== exp_d[k-3]) begin fails++; $display("FAIL wide_data k=%0d: got %h exp %h", k, o5_data, exp_d[k-3]); end
                tests++; if (o5_mode !== 2'(k-2)) begin fails++; $display("FAIL wide_mode k=%0d: got %0d exp %0d", k, o5_mode, k-2); end
            end
            if (k < 3) begin i5_valid = 1; i5_mode = 2'(k+1); i5_data = vec[k]; end
            else i5_valid = 0;
        end
    endtask

    // Same operands {1,0,1}, mode changes every beat.
    task automatic test_mode_per_beat();
        logic [0:0] exp_d [4];
        logic       ev;
        exp_d[0] = 1'b0; exp_d[1] = 1'b1; exp_d[2] = 1'b0; exp_d[3] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            ev = (k >= 2 && k < 6);
            tests++; if (o3_valid !== ev) begin fails++; $display("FAIL mode_valid k=%0d: got %b exp %b", k, o3_valid, ev); end
            if (ev) begin
                tests++; if (o3_data !== exp_d[k-2]) begin fails++; $display("FAIL mode_data k=%0d: got %b exp %b", k, o3_data, exp_d[k-2]); end
                tests++; if (o3_mode !== 2'(k-2)) begin fails++; $display("FAIL mode_mode k=%0d: got %0d exp %0d", k, o3_mode, k-2); end
            end
            if (k < 4) begin i3_valid = 1; i3_mode = 2'(k); i3_data = 3'b101; end
            else i3_valid = 0;
        end
    endtask

    // Six AND beats on N=4 with out_ready low for cycles 4..6.
    task automatic test_backpressure();
        int   exp_vld [12] = '{0,0,1,1,1,1,1,1,1,1,1,0};
        int   exp_dat [12] = '{0,0,1,2,3,3,3,3,4,5,6,0};
        int   exp_rdy [12] = '{1,1,1,1,0,0,0,1,1,1,1,1};
        int   nb = 1;
        int   next_exp = 1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            o4_ready = !(k >= 4 && k <= 6);
            #1;
            tests++; if (i4_ready !== 1'(exp_rdy[k])) begin fails++; $display("FAIL bp_in_ready k=%0d: got %b exp %0d", k, i4_ready, exp_rdy[k]); end
            tests++; if (o4_valid !== 1'(exp_vld[k])) begin fails++; $display("FAIL bp_valid k=%0d: got %b exp %0d", k, o4_valid, exp_vld[k]); end
            if (exp_vld[k] != 0) begin
                tests++; if (o4_data !== 4'(exp_dat[k])) begin fails++; $display("FAIL bp_data k=%0d: got %h exp %h", k, o4_data, exp_dat[k]); end
            end
            if (o4_valid === 1'b1 && o4_ready) begin
                tests++; if (o4_data !== 4'(next_exp)) begin fails++; $display("FAIL bp_order k=%0d: got %h exp %h", k, o4_data, next_exp); end
                next_exp++;
            end
            if (nb <= 6) begin
                i4_valid = 1; i4_mode = 2'd0;
                i4_data = {4'hF, 4'(nb | 8), 4'hF, 4'(nb)};
                if (exp_rdy[k] != 0) nb++;
            end else i4_valid = 0;
        end
        tests++; if (next_exp != 7) begin fails++; $display("FAIL bp_count: got %0d results exp 6", next_exp - 1); end
        o4_ready = 1;
    endtask

    // Async reset mid-flight: results vanish at once, none reappear.
    task automatic test_async_reset();
        @(negedge clk);
        i3_valid = 1; i3_mode = 2'd0; i3_data = 3'b111;
        @(negedge clk);
        @(negedge clk);
        i3_valid = 0;
        tests++; if (o3_valid !== 1'b1) begin fails++; $display("FAIL ar_pre_valid: got %b exp 1", o3_valid); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (o3_valid !== 1'b0) begin fails++; $display("FAIL ar_immediate: got %b exp 0", o3_valid); end
        tests++; if (o3_data !== 1'b0) begin fails++; $display("FAIL ar_data: got %b exp 0", o3_data); end
        #6;
        tests++; if (o3_valid !== 1'b0) begin fails++; $display("FAIL ar_held: got %b exp 0", o3_valid); end
        #3 rst_n = 1'b1;
        @(negedge clk);
        tests++; if (o3_valid !== 1'b0) begin fails++; $display("FAIL ar_stale1: got %b exp 0", o3_valid); end
        i3_valid = 1; i3_mode = 2'd2; i3_data = 3'b001;
        @(negedge clk);
        i3_valid = 0;
        tests++; if (o3_valid !== 1'b0) begin fails++; $display("FAIL ar_stale2: got %b exp 0", o3_valid); end
        @(negedge clk);
        tests++; if (o3_valid !== 1'b1) begin fails++; $display("FAIL ar_post_valid: got %b exp 1", o3_valid); end
        tests++; if (o3_data !== 1'b1) begin fails++; $display("FAIL ar_post_data: got %b exp 1", o3_data); end
        tests++; if (o3_mode !== 2'd2) begin fails++; $display("FAIL ar_post_mode: got %0d exp 2", o3_mode); end
        @(negedge clk);
        tests++; if (o3_valid !== 1'b0) begin fails++; $display("FAIL ar_after: got %b exp 0", o3_valid); end
    endtask

    // N=1 pass-through/NAND with one-cycle latency; N=4 OR with input gaps.
    task automatic test_single_and_gaps();
        int   gv  [6] = '{1,0,1,1,0,1};
        int   val [6] = '{3,0,5,9,0,6};
        logic ev;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k == 1) begin
                tests++; if (o1_valid !== 1'b1) begin fails++; $display("FAIL n1_valid0: got %b exp 1", o1_valid); end
                tests++; if (o1_data !== 4'b0101) begin fails++; $display("FAIL n1_nand: got %b exp 0101", o1_data); end
                tests++; if (o1_mode !== 2'd3) begin fails++; $display("FAIL n1_mode0: got %0d exp 3", o1_mode); end
            end else if (k == 2) begin
                tests++; if (o1_data !== 4'b0110) begin fails++; $display("FAIL n1_and: got %b exp 0110", o1_data); end
                tests++; if (o1_mode !== 2'd0) begin fails++; $display("FAIL n1_mode1: got %0d exp 0", o1_mode); end
            end else if (k == 3) begin
                tests++; if (o1_valid !== 1'b0) begin fails++; $display("FAIL n1_drain: got %b exp 0", o1_valid); end
            end
            if (k == 0) begin i1_valid = 1; i1_mode = 2'd3; i1_data = 4'b1010; end
            else if (k == 1) begin i1_valid = 1; i1_mode = 2'd0; i1_data = 4'b0110; end
            else i1_valid = 0;

            ev = (k >= 2 && k < 8) ? 1'(gv[k-2]) : 1'b0;
            tests++; if (o4_valid !== ev) begin fails++; $display("FAIL gap_valid k=%0d: got %b exp %b", k, o4_valid, ev); end
            if (ev) begin
                tests++; if (o4_data !== 4'(val[k-2])) begin fails++; $display("FAIL gap_data k=%0d: got %h exp %h", k, o4_data, val[k-2]); end
            end
            if (k < 6) begin
                i4_valid = 1'(gv[k]); i4_mode = 2'd1;
                i4_data = (gv[k] != 0) ? {4'(val[k] & 8), 4'(val[k] & 4), 4'(val[k] & 2), 4'(val[k] & 1)}
                                       : 16'hFFFF;
            end else i4_valid = 0;
        end
    endtask

    initial begin
        test_reset();
        test_and_combos();
        idle(2);
        test_wide();
        idle(2);
        test_mode_per_beat();
        idle(2);
        test_backpressure();
        idle(2);
        test_async_reset();
        idle(2);
        test_single_and_gaps();
        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
